// File: rtl/key_pkg.sv
// key_pkg: shared keyboard types and keycode constants for key_event and game FSMs.
package key_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE,
    KEY_HELD,
    KEY_REPEAT
  } key_state_t;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_Z     = 8'h1D;
  localparam logic [7:0] KEY_X     = 8'h1B;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;

endpackage

// File: rtl/key_stabilizer.sv
// key_stabilizer: accepts a raw keycode once it has been unchanged for STABLE_CYCLES clocks.
module key_stabilizer
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_raw,
  output logic [7:0] raw_q,
  output logic [7:0] code,
  output logic       accept
);

  localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] SAT = SW'(STABLE_CYCLES - 1);

  logic [SW-1:0] cnt;

  // Accept strobe: stable long enough and different from the currently accepted code.
  always_comb begin
    accept = (cnt == SAT) && (raw_q != code);
  end

  // Sample raw input, track stability, latch accepted code.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      raw_q <= KEY_NONE;
      cnt   <= '0;
      code  <= KEY_NONE;
    end else begin
      raw_q <= keycode_raw;
      if (keycode_raw != raw_q) begin
        cnt <= '0;
      end else if (cnt != SAT) begin
        cnt <= cnt + 1'b1;
      end
      if (accept) begin
        code <= raw_q;
      end
    end
  end

endmodule

// File: rtl/key_event.sv
// key_event: debounced held keycode plus press/release/auto-repeat event pulses.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_RATE   = 5_000_000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_raw,
  output logic [7:0] keycode,
  output logic       key_press,
  output logic       key_release,
  output logic [7:0] evt_code,
  output logic       is_repeat
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [7:0]       raw_q;
  logic             accept;
  key_state_t       state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic             press_n, release_n, repeat_n;
  logic [7:0]       evt_n;

  key_stabilizer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode_raw(keycode_raw),
    .raw_q      (raw_q),
    .code       (keycode),
    .accept     (accept)
  );

  // Next state, repeat timer and event outputs; acceptance outranks a repeat firing.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    press_n   = 1'b0;
    release_n = 1'b0;
    repeat_n  = is_repeat;
    evt_n     = evt_code;
    if (accept) begin
      timer_n = '0;
      if (raw_q == KEY_NONE) begin
        release_n = 1'b1;
        evt_n     = keycode;
        state_n   = KEY_IDLE;
      end else begin
        // Fresh press and rollover look the same here: new code, restart schedule.
        press_n  = 1'b1;
        repeat_n = 1'b0;
        evt_n    = raw_q;
        state_n  = KEY_HELD;
      end
    end else begin
      case (state)
        KEY_HELD: begin
          if (timer == DELAY_LAST) begin
            press_n  = 1'b1;
            repeat_n = 1'b1;
            evt_n    = keycode;
            timer_n  = '0;
            state_n  = KEY_REPEAT;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        KEY_REPEAT: begin
          if (timer == RATE_LAST) begin
            press_n  = 1'b1;
            repeat_n = 1'b1;
            evt_n    = keycode;
            timer_n  = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: begin
          timer_n = '0;
        end
      endcase
    end
  end

  // State, timer and registered event outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= KEY_IDLE;
      timer       <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      is_repeat   <= 1'b0;
      evt_code    <= KEY_NONE;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      key_press   <= press_n;
      key_release <= release_n;
      is_repeat   <= repeat_n;
      evt_code    <= evt_n;
    end
  end

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: randomized and directed checks of key_event against a run-length/schedule model.
module tb_key_event;
  import key_pkg::*;

  localparam int unsigned STABLE = 4;
  localparam int unsigned DELAY  = 20;
  localparam int unsigned RATE   = 8;

  logic       Clk;
  logic       Reset;
  logic [7:0] keycode_raw;
  logic [7:0] keycode;
  logic       key_press;
  logic       key_release;
  logic [7:0] evt_code;
  logic       is_repeat;

  int total;
  int bad;

  key_event #(
    .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE),
    .CNT_W        (8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode_raw(keycode_raw),
    .keycode    (keycode),
    .key_press  (key_press),
    .key_release(key_release),
    .evt_code   (evt_code),
    .is_repeat  (is_repeat)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a code is accepted once it has been the sampled raw value for
  // STABLE consecutive edges; repeats are scheduled as absolute edge numbers.
  int unsigned cyc;
  logic [7:0]  run_val;
  int unsigned run_len;
  logic [7:0]  m_kc, m_evt;
  logic        m_press, m_rel, m_rep, m_held;
  int unsigned next_rep;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_val = 8'h00; run_len = 1;
      m_kc = 8'h00; m_evt = 8'h00;
      m_press = 0; m_rel = 0; m_rep = 0; m_held = 0;
      next_rep = 0;
    end else begin
      cyc++;
      m_press = 0; m_rel = 0;
      if (run_len >= STABLE && run_val != m_kc) begin
        if (run_val == 8'h00) begin
          m_rel = 1; m_evt = m_kc; m_held = 0;
        end else begin
          m_press = 1; m_rep = 0; m_evt = run_val; m_held = 1;
          next_rep = cyc + DELAY;
        end
        m_kc = run_val;
      end else if (m_held && cyc == next_rep) begin
        m_press = 1; m_rep = 1; m_evt = m_kc;
        next_rep = cyc + RATE;
      end
      if (keycode_raw == run_val) run_len++;
      else begin run_val = keycode_raw; run_len = 1; end
    end
  end

  logic [7:0] keys [7];

  function automatic string outs_str();
    return $sformatf("got p=%b r=%b rep=%b evt=%h kc=%h, want p=%b r=%b rep=%b evt=%h kc=%h",
      key_press, key_release, is_repeat, evt_code, keycode,
      m_press, m_rel, m_rep, m_evt, m_kc);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    int presses = 0;
    int when = -1;
    Reset = 1'b0;
    keycode_raw = KEY_ENTER;
    repeat (3) @(negedge Clk);
    total++;
    if ({keycode, key_press, key_release, evt_code, is_repeat} !== 19'd0) begin
      bad++; $display("FAIL reset_values %s", outs_str());
    end
    Reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      total++;
      if ({key_press, key_release, is_repeat, evt_code, keycode} !== {m_press, m_rel, m_rep, m_evt, m_kc}) begin
        bad++; $display("FAIL reset_model i=%0d %s", i, outs_str());
      end
      if (key_press) begin presses++; when = i; end
    end
    total++;
    if (presses != 1 || when != 5 || keycode !== KEY_ENTER || evt_code !== KEY_ENTER) begin
      bad++; $display("FAIL reset_first_press got n=%0d at=%0d kc=%h want n=1 at=5 kc=28", presses, when, keycode);
    end
  endtask

  task automatic test_glitch();
    int events = 0;
    logic [7:0] k;
    keycode_raw = KEY_NONE;
    repeat (10) @(negedge Clk);
    for (int t = 0; t < 8; t++) begin
      keycode_raw = keys[$urandom_range(0, 6)];
      repeat ($urandom_range(1, 3)) @(negedge Clk);
      keycode_raw = KEY_NONE;
      for (int i = 0; i < 6; i++) begin
        @(negedge Clk);
        total++;
        if ({key_press, key_release, is_repeat, evt_code, keycode} !== {m_press, m_rel, m_rep, m_evt, m_kc}) begin
          bad++; $display("FAIL glitch_model t=%0d %s", t, outs_str());
        end
        if (key_press || key_release) events++;
      end
    end
    total++;
    if (events != 0 || keycode !== KEY_NONE) begin
      bad++; $display("FAIL glitch_idle got events=%0d kc=%h want 0 00", events, keycode);
    end
    k = keys[$urandom_range(0, 6)];
    keycode_raw = k;
    repeat (8) @(negedge Clk);
    events = 0;
    for (int t = 0; t < 3; t++) begin
      keycode_raw = (k == KEY_UP) ? KEY_DOWN : KEY_UP;
      repeat ($urandom_range(1, 3)) @(negedge Clk);
      keycode_raw = k;
      repeat (2) @(negedge Clk);
      if (key_release) events++;
    end
    total++;
    if (events != 0 || keycode !== k) begin
      bad++; $display("FAIL glitch_return got rel=%0d kc=%h want 0 %h", events, keycode, k);
    end
    keycode_raw = KEY_NONE;
    repeat (10) @(negedge Clk);
  endtask

  task automatic test_repeat();
    int times [$];
    keycode_raw = KEY_ENTER;
    for (int i = 1; i <= 60; i++) begin
      @(negedge Clk);
      total++;
      if ({key_press, key_release, is_repeat, evt_code, keycode} !== {m_press, m_rel, m_rep, m_evt, m_kc}) begin
        bad++; $display("FAIL repeat_model i=%0d %s", i, outs_str());
      end
      if (key_press) begin
        times.push_back(i);
        total++;
        if (is_repeat !== (times.size() > 1) || evt_code !== KEY_ENTER) begin
          bad++; $display("FAIL repeat_flag n=%0d got rep=%b evt=%h want rep=%b evt=28", times.size(), is_repeat, evt_code, times.size() > 1);
        end
      end
    end
    total++;
    if (times.size() != 6) begin
      bad++; $display("FAIL repeat_count got %0d want 6", times.size());
    end else begin
      for (int n = 1; n < 6; n++) begin
        total++;
        if (times[n] - times[0] != int'(DELAY + RATE * (n - 1))) begin
          bad++; $display("FAIL repeat_spacing n=%0d got %0d want %0d", n, times[n] - times[0], DELAY + RATE * (n - 1));
        end
      end
    end
  endtask

  task automatic test_release();
    int presses = 0;
    int rels = 0;
    keycode_raw = KEY_NONE;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clk);
      total++;
      if ({key_press, key_release, is_repeat, evt_code, keycode} !== {m_press, m_rel, m_rep, m_evt, m_kc}) begin
        bad++; $display("FAIL release_model i=%0d %s", i, outs_str());
      end
      if (key_press) presses++;
      if (key_release) begin
        rels++;
        total++;
        if (i != 5 || evt_code !== KEY_ENTER) begin
          bad++; $display("FAIL release_pulse got at=%0d evt=%h want at=5 evt=28", i, evt_code);
        end
      end
    end
    total++;
    if (presses != 0 || rels != 1 || keycode !== KEY_NONE) begin
      bad++; $display("FAIL release_counts got p=%0d r=%0d kc=%h want 0 1 00", presses, rels, keycode);
    end
  endtask

  task automatic test_rollover();
    int times [$];
    int rels = 0;
    keycode_raw = KEY_UP;
    for (int i = 1; i <= 50; i++) begin
      @(negedge Clk);
      total++;
      if ({key_press, key_release, is_repeat, evt_code, keycode} !== {m_press, m_rel, m_rep, m_evt, m_kc}) begin
        bad++; $display("FAIL rollover_model i=%0d %s", i, outs_str());
      end
      if (key_press) times.push_back(i);
      if (key_release) rels++;
      if (i == 15) keycode_raw = KEY_DOWN;
      if (i == 20) begin
        total++;
        if (key_press !== 1'b1 || is_repeat !== 1'b0 || evt_code !== KEY_DOWN) begin
          bad++; $display("FAIL rollover_press got p=%b rep=%b evt=%h want 1 0 51", key_press, is_repeat, evt_code);
        end
      end
    end
    total++;
    if (rels != 0 || times.size() != 4 || times[0] != 5 || times[1] != 20 || times[2] != 40 || times[3] != 48) begin
      bad++; $display("FAIL rollover_schedule got rel=%0d n=%0d times=%p want 0 4 {5,20,40,48}", rels, times.size(), times);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int presses = 0;
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    total++;
    if ({keycode, key_press, key_release, evt_code, is_repeat} !== 19'd0) begin
      bad++; $display("FAIL async_reset got kc=%h p=%b r=%b evt=%h rep=%b want all 0", keycode, key_press, key_release, evt_code, is_repeat);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge Clk);
      total++;
      if ({key_press, key_release, is_repeat, evt_code, keycode} !== {m_press, m_rel, m_rep, m_evt, m_kc}) begin
        bad++; $display("FAIL post_reset_model i=%0d %s", i, outs_str());
      end
      if (key_press) presses++;
    end
    total++;
    if (presses != 1 || is_repeat !== 1'b0 || evt_code !== KEY_DOWN) begin
      bad++; $display("FAIL post_reset_press got n=%0d rep=%b evt=%h want 1 0 51", presses, is_repeat, evt_code);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 40; s++) begin
      keycode_raw = ($urandom_range(0, 2) == 0) ? KEY_NONE : keys[$urandom_range(0, 6)];
      repeat ($urandom_range(1, 30)) begin
        @(negedge Clk);
        total++;
        if ({key_press, key_release, is_repeat, evt_code, keycode} !== {m_press, m_rel, m_rep, m_evt, m_kc}) begin
          bad++; $display("FAIL random_model seg=%0d %s", s, outs_str());
        end
        total++;
        if (key_press && key_release) begin
          bad++; $display("FAIL random_exclusive got p=1 r=1 want not both");
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    keys = '{KEY_ENTER, KEY_Z, KEY_X, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};
    Reset = 1'b0;
    keycode_raw = KEY_NONE;
    @(negedge Clk);
    test_reset();
    test_glitch();
    test_repeat();
    test_release();
    test_rollover();
    test_reset_mid_repeat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
